mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit downstream of the register bank. It consumes
//  the two read ports (DR1 -> a, DR2 -> b) for MULT/MULTU/DIV/DIVU and holds the
//  results in architectural HI/LO registers for later MFHI/MFLO write-back (Di).
//  Shift-add / restoring-divide datapath; one bit per clock; start/busy/done handshake.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  op       in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  a        in   WIDTH  operand A / dividend (from DR1)
//  b        in   WIDTH  operand B / divisor (from DR2)
//  busy     out  1      operation in progress (states BUSY, FIX)
//  done     out  1      one-cycle pulse: hi/lo/dz just updated
//  hi       out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo       out  WIDTH  MULT: product[W-1:0];  DIV: quotient
//  dz       out  1      last DIV/DIVU had b==0; held until the next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, hi=0, lo=0, dz=0; counter=0.
//  FSM: IDLE -> BUSY on start. BUSY -> FIX after WIDTH iterations. FIX -> IDLE.
//  Edge E0 (start=1 in IDLE): latch op and |a|,|b| (abs only for signed ops).
//   Record result signs: MULT sign=a^b; DIV quotient sign=a^b, remainder sign=a.
//   Clear accumulator and counter; dz <= (op[1] && b==0); busy goes 1.
//  Edges E1..EWIDTH (BUSY): one iteration per edge. MUL: shift-add on 2W-bit
//   accumulator. DIV: restoring step, quotient bit = (partial rem >= divisor).
//  Edge E(WIDTH+1): state=FIX; apply two's-complement sign correction (signed ops).
//  Edge E(WIDTH+2): hi/lo loaded; done=1 for exactly this one cycle; busy=0;
//   state=IDLE. A start in that same cycle is accepted (back-to-back allowed).
//  Latency: done high WIDTH+2 cycles after the start edge; 34 cycles at WIDTH=32.
//  hi/lo hold previous values throughout BUSY/FIX. No partial updates.
//  start while busy: ignored; no queueing. op/a/b may change after E0.
//  Divide by zero: no exception. lo = all ones, hi = dividend a (unmodified).
//   Both DIV and DIVU; dz=1.
//  Signed overflow DIV 0x80000000 / -1: lo=0x80000000, hi=0; dz=0.
//  Magnitudes are handled as WIDTH-bit unsigned, so |0x80000000| is exact.
//  Remainder takes the sign of the dividend. Quotient truncates toward zero.
//  Reset mid-operation: abort immediately; no done pulse; hi/lo forced to 0.
// TESTING
//  1 MULT a=0xFFFFFFFD(-3) b=5 -> done at +34 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2 MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy=1 for 34 cycles.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7, dz=1.
//    Next MULTU 3*4 -> dz=0 from its start edge; lo=12, hi=0.
//  5 start pulsed at cycles +5 and +20 during busy -> ignored; single done, result unchanged.
//    start held high -> second op accepted on the done cycle.
//  6 rst asserted at cycle +10 of a DIV (asynchronous, between edges) -> busy/done/hi/lo/dz=0 at once.
//    No done afterward; a fresh MULTU 6*7 after release gives lo=42.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// Results are held in HI/LO until the next operation completes.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [1:0]         op_r;
   logic               neg_q;
   logic               neg_r;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;

   logic               is_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? -v : v;
   endfunction

   assign is_signed = ~op[0];
   assign a_mag     = magnitude(a, is_signed);
   assign b_mag     = magnitude(b, is_signed);

   // Multiply keeps the multiplicand in opnd and the multiplier in acc's low half;
   // divide keeps the divisor in opnd and shifts the dividend out of acc's low half.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge   = div_part >= {1'b0, opnd};
      div_diff = div_part - {1'b0, opnd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         dz    <= 1'b0;
         cnt   <= '0;
         op_r  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         opnd  <= '0;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r  <= op;
                  opnd  <= op[1] ? b_mag : a_mag;
                  acc   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                  neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= is_signed & a[WIDTH-1];
                  dz    <= op[1] && (b == '0);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == CW'(WIDTH)) begin
                  // A zero divisor yields an all-ones quotient, left unsigned;
                  // the remainder is |a| re-signed, which reproduces a exactly.
                  if (!op_r[1]) begin
                     acc <= neg_q ? -acc : acc;
                  end else begin
                     acc <= {apply_sign(acc[2*WIDTH-1:WIDTH], neg_r),
                             apply_sign(acc[WIDTH-1:0], neg_q && !dz)};
                  end
                  state <= FIX;
               end else begin
                  if (!op_r[1]) begin
                     acc <= {mul_sum, acc[WIDTH-1:1]};
                  end else begin
                     acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                             acc[WIDTH-2:0], div_ge};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               hi    <= acc[2*WIDTH-1:WIDTH];
               lo    <= acc[WIDTH-1:0];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
